// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-to-hazard-controller signal bundle
interface hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [31:0] Instr_id_i;
  logic [31:0] Instr_ex_i;
  logic MemRead_ex_i;
  logic branch_taken_id_i;
  logic jump_id_i;
  logic md_start_ex_i;
  logic md_use_id_i;
  logic stall_o;
  logic IF_flush_o;
  logic pc_write_o;
  logic ifid_write_o;
  logic md_busy_o;
  logic [CNT_W-1:0] stall_cnt_o;
  modport master (
    output Instr_id_i, Instr_ex_i, MemRead_ex_i, branch_taken_id_i, jump_id_i, md_start_ex_i, md_use_id_i,
    input stall_o, IF_flush_o, pc_write_o, ifid_write_o, md_busy_o, stall_cnt_o
  );
  modport slave (
    input Instr_id_i, Instr_ex_i, MemRead_ex_i, branch_taken_id_i, jump_id_i, md_start_ex_i, md_use_id_i,
    output stall_o, IF_flush_o, pc_write_o, ifid_write_o, md_busy_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / mult-div stall, branch flush and saturating stall counter
module hazard_ctrl #(
  parameter int MD_LAT = 8,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic rst,
  hazard_ctrl_if.slave h
);
  localparam int CW = $clog2(MD_LAT);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [CW-1:0] md_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [4:0] rt_ex, rs_id, rt_id;
  logic lu, md_busy, stall;
  assign rt_ex = h.Instr_ex_i[20:16];
  assign rs_id = h.Instr_id_i[25:21];
  assign rt_id = h.Instr_id_i[20:16];
  assign lu = h.MemRead_ex_i & (rt_ex != 5'd0) & (rt_ex == rs_id | rt_ex == rt_id);
  // Outputs are forced to their idle values while reset is held low, even before the edge
  assign md_busy = rst & (state == BUSY);
  assign stall = rst & (lu | (md_busy & h.md_use_id_i));
  assign h.stall_o = stall;
  assign h.pc_write_o = ~stall;
  assign h.ifid_write_o = ~stall;
  assign h.IF_flush_o = rst & (h.branch_taken_id_i | h.jump_id_i) & ~stall;
  assign h.md_busy_o = md_busy;
  assign h.stall_cnt_o = stall_cnt;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      md_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (state == IDLE) begin
        if (h.md_start_ex_i) begin
          state <= BUSY;
          md_cnt <= CW'(MD_LAT - 1);
        end
      end else begin
        md_cnt <= md_cnt - 1'b1;
        if (md_cnt == '0) state <= IDLE;
      end
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl with MD_LAT=8, CNT_W=4
module tb_hazard_ctrl;
  logic clk = 0;
  logic rst = 0;
  int errors = 0;
  int checks = 0;
  hazard_ctrl_if #(.CNT_W(4)) hif();
  hazard_ctrl #(.MD_LAT(8), .CNT_W(4)) dut (.clk(clk), .rst(rst), .h(hif.slave));
  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input logic [4:0] rs, input logic [4:0] rt);
    return {6'd0, rs, rt, 16'd0};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear();
    hif.Instr_id_i = 0; hif.Instr_ex_i = 0; hif.MemRead_ex_i = 0;
    hif.branch_taken_id_i = 0; hif.jump_id_i = 0; hif.md_start_ex_i = 0; hif.md_use_id_i = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    step();
    rst = 1;
  endtask

  task automatic test_reset();
    clear();
    rst = 0;
    hif.Instr_ex_i = ins(0, 8); hif.MemRead_ex_i = 1; hif.Instr_id_i = ins(8, 1); hif.branch_taken_id_i = 1;
    step();
    checks++; if (hif.stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", hif.stall_o); end
    checks++; if (hif.IF_flush_o !== 1'b0) begin errors++; $display("FAIL rst_flush got %b exp 0", hif.IF_flush_o); end
    checks++; if (hif.pc_write_o !== 1'b1) begin errors++; $display("FAIL rst_pcw got %b exp 1", hif.pc_write_o); end
    checks++; if (hif.ifid_write_o !== 1'b1) begin errors++; $display("FAIL rst_ifidw got %b exp 1", hif.ifid_write_o); end
    checks++; if (hif.md_busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", hif.md_busy_o); end
    checks++; if (hif.stall_cnt_o !== 4'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", hif.stall_cnt_o); end
    clear();
    rst = 1;
    #1;
  endtask

  task automatic test_load_use();
    hif.Instr_ex_i = ins(3, 8); hif.MemRead_ex_i = 1; hif.Instr_id_i = ins(8, 2);
    #1;
    checks++; if (hif.stall_o !== 1'b1) begin errors++; $display("FAIL lu_stall got %b exp 1", hif.stall_o); end
    checks++; if (hif.pc_write_o !== 1'b0) begin errors++; $display("FAIL lu_pcw got %b exp 0", hif.pc_write_o); end
    checks++; if (hif.ifid_write_o !== 1'b0) begin errors++; $display("FAIL lu_ifidw got %b exp 0", hif.ifid_write_o); end
    checks++; if (hif.IF_flush_o !== 1'b0) begin errors++; $display("FAIL lu_flush got %b exp 0", hif.IF_flush_o); end
    step();
    hif.MemRead_ex_i = 0; hif.Instr_ex_i = 0;
    #1;
    checks++; if (hif.stall_o !== 1'b0) begin errors++; $display("FAIL lu_bubble got %b exp 0", hif.stall_o); end
    checks++; if (hif.pc_write_o !== 1'b1) begin errors++; $display("FAIL lu_bubble_pcw got %b exp 1", hif.pc_write_o); end
    checks++; if (hif.stall_cnt_o !== 4'd1) begin errors++; $display("FAIL lu_cnt got %0d exp 1", hif.stall_cnt_o); end
    clear();
  endtask

  task automatic test_zero_reg();
    hif.Instr_ex_i = ins(4, 0); hif.MemRead_ex_i = 1; hif.Instr_id_i = ins(0, 0);
    #1;
    checks++; if (hif.stall_o !== 1'b0) begin errors++; $display("FAIL zero_stall got %b exp 0", hif.stall_o); end
    hif.Instr_ex_i = ins(4, 9); hif.Instr_id_i = ins(3, 9);
    #1;
    checks++; if (hif.stall_o !== 1'b1) begin errors++; $display("FAIL rt_match_stall got %b exp 1", hif.stall_o); end
    hif.MemRead_ex_i = 0;
    #1;
    checks++; if (hif.stall_o !== 1'b0) begin errors++; $display("FAIL no_load_stall got %b exp 0", hif.stall_o); end
    hif.MemRead_ex_i = 1;
    step();
    clear();
    #1;
    checks++; if (hif.stall_cnt_o !== 4'd2) begin errors++; $display("FAIL zero_cnt got %0d exp 2", hif.stall_cnt_o); end
  endtask

  task automatic test_branch();
    hif.branch_taken_id_i = 1;
    #1;
    checks++; if (hif.IF_flush_o !== 1'b1) begin errors++; $display("FAIL br_flush got %b exp 1", hif.IF_flush_o); end
    step();
    hif.Instr_ex_i = ins(0, 7); hif.MemRead_ex_i = 1; hif.Instr_id_i = ins(7, 1);
    #1;
    checks++; if (hif.IF_flush_o !== 1'b0) begin errors++; $display("FAIL br_lu_flush got %b exp 0", hif.IF_flush_o); end
    checks++; if (hif.stall_o !== 1'b1) begin errors++; $display("FAIL br_lu_stall got %b exp 1", hif.stall_o); end
    step();
    hif.MemRead_ex_i = 0; hif.Instr_ex_i = 0;
    #1;
    checks++; if (hif.IF_flush_o !== 1'b1) begin errors++; $display("FAIL br_after_flush got %b exp 1", hif.IF_flush_o); end
    checks++; if (hif.stall_o !== 1'b0) begin errors++; $display("FAIL br_after_stall got %b exp 0", hif.stall_o); end
    step();
    clear();
    hif.jump_id_i = 1;
    #1;
    checks++; if (hif.IF_flush_o !== 1'b1) begin errors++; $display("FAIL jump_flush got %b exp 1", hif.IF_flush_o); end
    checks++; if (hif.stall_cnt_o !== 4'd3) begin errors++; $display("FAIL br_cnt got %0d exp 3", hif.stall_cnt_o); end
    step();
    clear();
  endtask

  task automatic test_md();
    hif.md_start_ex_i = 1; hif.md_use_id_i = 1;
    #1;
    checks++; if (hif.md_busy_o !== 1'b0 || hif.stall_o !== 1'b0) begin errors++; $display("FAIL md_T busy=%b stall=%b exp 0 0", hif.md_busy_o, hif.stall_o); end
    step();
    hif.md_start_ex_i = 0;
    for (int i = 1; i <= 8; i++) begin
      #1;
      checks++; if (hif.md_busy_o !== 1'b1 || hif.stall_o !== 1'b1) begin errors++; $display("FAIL md_use_T+%0d busy=%b stall=%b exp 1 1", i, hif.md_busy_o, hif.stall_o); end
      step();
    end
    #1;
    checks++; if (hif.md_busy_o !== 1'b0 || hif.stall_o !== 1'b0) begin errors++; $display("FAIL md_use_T+9 busy=%b stall=%b exp 0 0", hif.md_busy_o, hif.stall_o); end
    checks++; if (hif.stall_cnt_o !== 4'd11) begin errors++; $display("FAIL md_cnt got %0d exp 11", hif.stall_cnt_o); end
    hif.md_use_id_i = 0; hif.md_start_ex_i = 1;
    step();
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) hif.md_start_ex_i = 0;
      #1;
      checks++; if (hif.md_busy_o !== 1'b1 || hif.stall_o !== 1'b0) begin errors++; $display("FAIL md_nouse_T+%0d busy=%b stall=%b exp 1 0", i, hif.md_busy_o, hif.stall_o); end
      step();
    end
    #1;
    checks++; if (hif.md_busy_o !== 1'b0) begin errors++; $display("FAIL md_nouse_T+9 busy=%b exp 0", hif.md_busy_o); end
    checks++; if (hif.stall_cnt_o !== 4'd11) begin errors++; $display("FAIL md_nouse_cnt got %0d exp 11", hif.stall_cnt_o); end
    clear();
  endtask

  task automatic test_saturate();
    do_reset();
    hif.Instr_ex_i = ins(0, 5); hif.MemRead_ex_i = 1; hif.Instr_id_i = ins(5, 5);
    for (int k = 1; k <= 20; k++) begin
      step();
      checks++; if (hif.stall_cnt_o !== 4'((k > 15) ? 15 : k)) begin errors++; $display("FAIL sat_cnt_%0d got %0d exp %0d", k, hif.stall_cnt_o, (k > 15) ? 15 : k); end
    end
    clear();
  endtask

  task automatic test_reset_busy();
    do_reset();
    hif.md_start_ex_i = 1;
    step();
    hif.md_start_ex_i = 0;
    step();
    step();
    #1;
    checks++; if (hif.md_busy_o !== 1'b1) begin errors++; $display("FAIL rb_busy3 got %b exp 1", hif.md_busy_o); end
    rst = 0; hif.md_use_id_i = 1;
    #1;
    checks++; if (hif.stall_o !== 1'b0) begin errors++; $display("FAIL rb_rstlow_stall got %b exp 0", hif.stall_o); end
    step();
    rst = 1;
    #1;
    checks++; if (hif.md_busy_o !== 1'b0) begin errors++; $display("FAIL rb_busy got %b exp 0", hif.md_busy_o); end
    checks++; if (hif.stall_o !== 1'b0) begin errors++; $display("FAIL rb_stall got %b exp 0", hif.stall_o); end
    checks++; if (hif.stall_cnt_o !== 4'd0) begin errors++; $display("FAIL rb_cnt got %0d exp 0", hif.stall_cnt_o); end
    hif.md_use_id_i = 0; hif.Instr_ex_i = ins(0, 6); hif.MemRead_ex_i = 1; hif.Instr_id_i = ins(6, 0);
    #1;
    checks++; if (hif.stall_o !== 1'b1) begin errors++; $display("FAIL rb_post_stall got %b exp 1", hif.stall_o); end
    step();
    checks++; if (hif.stall_cnt_o !== 4'd1) begin errors++; $display("FAIL rb_post_cnt got %0d exp 1", hif.stall_cnt_o); end
    clear();
  endtask

  initial begin
    clear();
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch();
    test_md();
    test_saturate();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
